// File: rtl/vga_timing_controller_if.sv
// vga_timing_controller_if
// Bundles the video RAM read port and the VGA pin outputs of the timing
// controller.
//   Enable           hold control for the whole controller
//   iPixel           {R,G,B} returned by video RAM, one clock after the address
//   oReadAddress     video RAM read address
//   oHorizontalSync  HSYNC pin
//   oVerticalSync    VSYNC pin
//   oRed/oGreen/oBlue colour pins
//   oColumn/oRow     coordinates of the pixel currently on the pins
//   oFrameStart      one-clock pulse when pixel (0,0) is on the pins
// The master modport is the controller; the slave modport is the RAM/board side.
interface vga_timing_controller_if;
    logic        Enable;
    logic [2:0]  iPixel;
    logic [18:0] oReadAddress;
    logic        oHorizontalSync;
    logic        oVerticalSync;
    logic        oRed;
    logic        oGreen;
    logic        oBlue;
    logic [9:0]  oColumn;
    logic [9:0]  oRow;
    logic        oFrameStart;

    modport master (
        input  Enable, iPixel,
        output oReadAddress, oHorizontalSync, oVerticalSync,
               oRed, oGreen, oBlue, oColumn, oRow, oFrameStart
    );

    modport slave (
        output Enable, iPixel,
        input  oReadAddress, oHorizontalSync, oVerticalSync,
               oRed, oGreen, oBlue, oColumn, oRow, oFrameStart
    );
endinterface

// File: rtl/vga_timing_controller.sv
// vga_timing_controller
// Generates VGA raster timing from the system clock through a clock divider,
// issues the video RAM read address, and registers the returned pixel with
// the sync signals so colour and sync leave the block aligned.
//   Clock  system clock, rising edge
//   Reset  asynchronous, active-low
//   bus    vga_timing_controller_if.master (RAM read port and VGA pins)
// Pipeline: counters -> stage 1 (address, sync decode, coordinates)
//           -> stage 2 (pins). A pixel reaches the pins two ticks after the
// counters reach it.
module vga_timing_controller #(
    parameter int   H_VISIBLE   = 640,
    parameter int   H_FRONT     = 16,
    parameter int   H_SYNC      = 96,
    parameter int   H_BACK      = 48,
    parameter int   V_VISIBLE   = 480,
    parameter int   V_FRONT     = 10,
    parameter int   V_SYNC      = 2,
    parameter int   V_BACK      = 33,
    parameter int   CLK_DIV     = 2,
    parameter logic SYNC_ACTIVE = 1'b0
) (
    input  logic                          Clock,
    input  logic                          Reset,
    vga_timing_controller_if.master       bus
);

    localparam int DIV_W = $clog2(CLK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
    localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [9:0] H_LAST   = 10'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
    localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
    localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);
    localparam logic [9:0] V_LAST   = 10'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
    localparam logic [18:0] LINE_WORDS = 19'(H_VISIBLE);

    logic [DIV_W-1:0] divider;
    logic             tick;
    logic [9:0]       hcount;
    logic [9:0]       vcount;

    logic             visible_now;
    logic             hs_now;
    logic             vs_now;
    logic [18:0]      addr_now;

    // stage 1
    logic             valid1;
    logic             visible1;
    logic             hs1;
    logic             vs1;
    logic [9:0]       col1;
    logic [9:0]       row1;

    assign tick = bus.Enable && (divider == DIV_LAST);

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            divider <= '0;
        end else if (bus.Enable) begin
            divider <= tick ? '0 : divider + 1'b1;
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            hcount <= '0;
            vcount <= '0;
        end else if (tick) begin
            if (hcount == H_LAST) begin
                hcount <= '0;
                vcount <= (vcount == V_LAST) ? '0 : vcount + 1'b1;
            end else begin
                hcount <= hcount + 1'b1;
            end
        end
    end

    always_comb begin
        visible_now = (hcount < H_VIS) && (vcount < V_VIS);
        hs_now      = (hcount >= HS_START) && (hcount < HS_END);
        vs_now      = (vcount >= VS_START) && (vcount < VS_END);
        addr_now    = visible_now ? (19'(vcount) * LINE_WORDS + 19'(hcount)) : '0;
    end

    // valid1 keeps the reset-cleared (0,0) coordinates in stage 1 from
    // producing a frame-start pulse before the counters have fed real data.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            valid1           <= 1'b0;
            visible1         <= 1'b0;
            hs1              <= ~SYNC_ACTIVE;
            vs1              <= ~SYNC_ACTIVE;
            col1             <= '0;
            row1             <= '0;
            bus.oReadAddress <= '0;
        end else if (tick) begin
            valid1           <= 1'b1;
            visible1         <= visible_now;
            hs1              <= hs_now ? SYNC_ACTIVE : ~SYNC_ACTIVE;
            vs1              <= vs_now ? SYNC_ACTIVE : ~SYNC_ACTIVE;
            col1             <= hcount;
            row1             <= vcount;
            bus.oReadAddress <= addr_now;
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            bus.oHorizontalSync <= ~SYNC_ACTIVE;
            bus.oVerticalSync   <= ~SYNC_ACTIVE;
            bus.oRed            <= 1'b0;
            bus.oGreen          <= 1'b0;
            bus.oBlue           <= 1'b0;
            bus.oColumn         <= '0;
            bus.oRow            <= '0;
        end else if (tick) begin
            bus.oHorizontalSync <= hs1;
            bus.oVerticalSync   <= vs1;
            {bus.oRed, bus.oGreen, bus.oBlue} <= visible1 ? bus.iPixel : 3'b000;
            bus.oColumn         <= col1;
            bus.oRow            <= row1;
        end
    end

    // Re-evaluated every clock so the pulse is exactly one clock wide; tick is
    // low while Enable is low, so a held controller never stretches it.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            bus.oFrameStart <= 1'b0;
        end else begin
            bus.oFrameStart <= tick && valid1 && (col1 == '0) && (row1 == '0);
        end
    end

endmodule
